// File: rtl/n64adv2_joybus_tx_if.sv
// rtl/n64adv2_joybus_tx_if.sv - Request/status bundle for the Joybus transmitter
interface n64adv2_joybus_tx_if;
    logic        tx_start_i;
    logic [5:0]  tx_nbits_i;
    logic [31:0] tx_data_i;
    logic        tx_stop_mode_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    modport master (
        output tx_start_i, tx_nbits_i, tx_data_i, tx_stop_mode_i,
        input  busy_o, done_o, err_o
    );

    modport slave (
        input  tx_start_i, tx_nbits_i, tx_data_i, tx_stop_mode_i,
        output busy_o, done_o, err_o
    );
endinterface

// File: rtl/n64adv2_joybus_tx.sv
// rtl/n64adv2_joybus_tx.sv - Joybus open-drain transmitter with stop bit and collision check
module n64adv2_joybus_tx #(
    parameter int T_US    = 49,
    parameter int IDLE_US = 64
) (
    input  logic               N64_CLK_i,
    input  logic               CTRL_nRST,
    input  logic               CTRL_i,
    output logic               CTRL_oe_o,
    n64adv2_joybus_tx_if.slave tx
);
    localparam int IDLE_CYC = IDLE_US * T_US;
    localparam int IDLE_W   = $clog2(IDLE_CYC + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYC - 1);
    localparam logic [9:0] L1 = 10'(T_US);
    localparam logic [9:0] L2 = 10'(2 * T_US);
    localparam logic [9:0] L3 = 10'(3 * T_US);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_IDLE, S_BIT_LOW, S_BIT_HIGH, S_STOP_LOW, S_STOP_HIGH
    } state_t;

    state_t            state_q, state_d;
    logic [9:0]        cnt_q, cnt_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [4:0]        bit_idx_q, bit_idx_d;
    logic [31:0]       data_q, data_d;
    logic [5:0]        nbits_q, nbits_d;
    logic              mode_q, mode_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              oe_q, oe_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;

    logic       cur_bit, last_bit, phase_end, collide, nbits_bad;
    logic [9:0] phase_len;

    always_comb begin
        cur_bit = data_q[bit_idx_q];
        case (state_q)
            S_BIT_LOW:  phase_len = cur_bit ? L1 : L3;
            S_BIT_HIGH: phase_len = cur_bit ? L3 : L1;
            S_STOP_LOW: phase_len = mode_q ? L2 : L1;
            default:    phase_len = L2;
        endcase
        phase_end = (cnt_q == phase_len - 10'd1);
        last_bit  = ({1'b0, bit_idx_q} == nbits_q - 6'd1);
        // The first 3 released cycles still see the synchronized tail of our own low drive.
        collide   = !sync2_q && (cnt_q >= 10'd3);
        nbits_bad = (tx.tx_nbits_i == 6'd0) || (tx.tx_nbits_i > 6'd32);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 10'd1;
        idle_cnt_d = idle_cnt_q;
        bit_idx_d  = bit_idx_q;
        data_d     = data_q;
        nbits_d    = nbits_q;
        mode_d     = mode_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        sync1_d    = CTRL_i;
        sync2_d    = sync1_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = 10'd0;
                if (tx.tx_start_i) begin
                    if (nbits_bad) begin
                        err_d = 1'b1;
                    end else begin
                        data_d     = tx.tx_data_i;
                        nbits_d    = tx.tx_nbits_i;
                        mode_d     = tx.tx_stop_mode_i;
                        busy_d     = 1'b1;
                        idle_cnt_d = '0;
                        state_d    = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                cnt_d = 10'd0;
                if (!sync2_q) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    bit_idx_d = 5'd0;
                    state_d   = S_BIT_LOW;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            S_BIT_LOW: begin
                if (phase_end) begin
                    cnt_d   = 10'd0;
                    state_d = S_BIT_HIGH;
                end
            end
            S_BIT_HIGH: begin
                if (collide) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (phase_end) begin
                    cnt_d = 10'd0;
                    if (last_bit) begin
                        state_d = S_STOP_LOW;
                    end else begin
                        bit_idx_d = bit_idx_q + 5'd1;
                        state_d   = S_BIT_LOW;
                    end
                end
            end
            S_STOP_LOW: begin
                if (phase_end) begin
                    cnt_d   = 10'd0;
                    state_d = S_STOP_HIGH;
                end
            end
            S_STOP_HIGH: begin
                if (collide) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (phase_end) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        oe_d = (state_d == S_BIT_LOW) || (state_d == S_STOP_LOW);
    end

    always_ff @(posedge N64_CLK_i or negedge CTRL_nRST) begin
        if (!CTRL_nRST) begin
            state_q    <= S_IDLE;
            cnt_q      <= 10'd0;
            idle_cnt_q <= '0;
            bit_idx_q  <= 5'd0;
            data_q     <= 32'd0;
            nbits_q    <= 6'd0;
            mode_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            oe_q       <= 1'b0;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idle_cnt_q <= idle_cnt_d;
            bit_idx_q  <= bit_idx_d;
            data_q     <= data_d;
            nbits_q    <= nbits_d;
            mode_q     <= mode_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            oe_q       <= oe_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
        end
    end

    assign CTRL_oe_o = oe_q;
    assign tx.busy_o = busy_q;
    assign tx.done_o = done_q;
    assign tx.err_o  = err_q;
endmodule

// File: tb/tb_n64adv2_joybus_tx.sv
// tb/tb_n64adv2_joybus_tx.sv - Vector-table bench for the Joybus transmitter
module tb_n64adv2_joybus_tx;
    localparam int TUS    = 4;
    localparam int IDLEUS = 2;
    localparam int BUDGET = 700;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nrst;
    logic force_low;
    logic ctrl_i;
    logic oe;

    n64adv2_joybus_tx_if bus();

    // Open-drain line: low when the DUT drives or the bench forces a collision.
    assign ctrl_i = ~(oe | force_low);

    n64adv2_joybus_tx #(.T_US(TUS), .IDLE_US(IDLEUS)) dut (
        .N64_CLK_i (clk),
        .CTRL_nRST (nrst),
        .CTRL_i    (ctrl_i),
        .CTRL_oe_o (oe),
        .tx        (bus)
    );

    typedef struct {
        string       name;
        logic [5:0]  nb;
        logic [31:0] d;
        logic        m;
        int          force_at;
        int          restart_at;
        bit          acc;
        int          exp_first;
        int          exp_end;
        bit          exp_done;
    } vec_t;

    vec_t vecs[10];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic oe_w   [0:1023];
    logic busy_w [0:1023];

    function automatic vec_t mk(input string name, input logic [5:0] nb, input logic [31:0] d,
                                input logic m, input int force_at, input int restart_at,
                                input bit acc, input int exp_first, input int exp_end,
                                input bit exp_done);
        vec_t v;
        v.name = name; v.nb = nb; v.d = d; v.m = m;
        v.force_at = force_at; v.restart_at = restart_at; v.acc = acc;
        v.exp_first = exp_first; v.exp_end = exp_end; v.exp_done = exp_done;
        return v;
    endfunction

    // Expected line drive for cycle c, built from the Joybus bit timing.
    function automatic logic model_oe(input vec_t v, input int c);
        int p;
        int lo;
        if (v.exp_first < 0 || c < v.exp_first || c >= v.exp_end) return 1'b0;
        p = c - v.exp_first;
        for (int i = 0; i < int'(v.nb); i++) begin
            lo = v.d[i] ? TUS : 3 * TUS;
            if (p < lo) return 1'b1;
            p -= lo;
            if (p < 4 * TUS - lo) return 1'b0;
            p -= 4 * TUS - lo;
        end
        lo = v.m ? 2 * TUS : TUS;
        return (p < lo);
    endfunction

    task automatic check_eq(input string name, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int  first_c;
        int  end_c;
        int  last_c;
        int  pulses;
        int  mism;
        bit  end_done;
        bus.tx_nbits_i     = v.nb;
        bus.tx_data_i      = v.d;
        bus.tx_stop_mode_i = v.m;
        bus.tx_start_i     = 1'b1;
        first_c = -1; end_c = -1; last_c = 0; pulses = 0; end_done = 1'b0;
        for (int c = 1; c < BUDGET; c++) begin
            @(negedge clk);
            bus.tx_start_i = (c == v.restart_at);
            if (c == v.restart_at) begin
                bus.tx_data_i      = 32'hFFFF_FFFF;
                bus.tx_nbits_i     = 6'd3;
                bus.tx_stop_mode_i = ~v.m;
            end
            force_low = (c == v.force_at);
            oe_w[c]   = oe;
            busy_w[c] = bus.busy_o;
            last_c    = c;
            if (oe && first_c < 0) first_c = c;
            if (bus.done_o || bus.err_o) begin
                pulses++;
                if (end_c < 0) begin
                    end_c    = c;
                    end_done = bus.done_o;
                end
            end
            if (end_c >= 0 && c >= end_c + 6) break;
        end
        force_low      = 1'b0;
        bus.tx_start_i = 1'b0;
        mism = 0;
        for (int c = 1; c <= last_c; c++)
            if (oe_w[c] !== model_oe(v, c)) mism++;
        check_eq({tag, v.name, ".busy1"}, busy_w[1], v.acc);
        check_eq({tag, v.name, ".first_oe"}, first_c, v.exp_first);
        check_eq({tag, v.name, ".end_cycle"}, end_c, v.exp_end);
        check_eq({tag, v.name, ".done_not_err"}, end_done, v.exp_done);
        check_eq({tag, v.name, ".pulses"}, pulses, 1);
        check_eq({tag, v.name, ".wave_mismatches"}, mism, 0);
        if (end_c > 1) begin
            check_eq({tag, v.name, ".busy_fall"}, {busy_w[end_c - 1], busy_w[end_c]},
                     v.acc ? 2 : 0);
        end
    endtask

    initial begin
        vecs[0] = mk("cmd01",    6'd8,  32'h80,        1'b0, -1,  -1, 1'b1,  9, 149, 1'b1);
        vecs[1] = mk("resp32",   6'd32, 32'h0000FFFF,  1'b1, -1,  -1, 1'b1,  9, 537, 1'b1);
        vecs[2] = mk("nb1",      6'd1,  32'h1,         1'b1, -1,  -1, 1'b1,  9,  41, 1'b1);
        vecs[3] = mk("coll",     6'd8,  32'h04,        1'b0, 46,  -1, 1'b1,  9,  49, 1'b0);
        vecs[4] = mk("blank",    6'd8,  32'h04,        1'b0, 45,  -1, 1'b1,  9, 149, 1'b1);
        vecs[5] = mk("stopcoll", 6'd8,  32'h80,        1'b0, 146, -1, 1'b1,  9, 149, 1'b0);
        vecs[6] = mk("glitch",   6'd8,  32'h80,        1'b0, 5,   -1, 1'b1, 16, 156, 1'b1);
        vecs[7] = mk("restart",  6'd8,  32'h80,        1'b0, -1,  30, 1'b1,  9, 149, 1'b1);
        vecs[8] = mk("rej0",     6'd0,  32'h80,        1'b0, -1,  -1, 1'b0, -1,   1, 1'b0);
        vecs[9] = mk("rej33",    6'd33, 32'h80,        1'b0, -1,  -1, 1'b0, -1,   1, 1'b0);

        nrst = 1'b0;
        force_low = 1'b0;
        bus.tx_start_i = 1'b0;
        bus.tx_nbits_i = 6'd0;
        bus.tx_data_i = 32'd0;
        bus.tx_stop_mode_i = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset.outputs", {oe, bus.busy_o, bus.done_o, bus.err_o}, 0);
        nrst = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("reset.released_outputs", {oe, bus.busy_o, bus.done_o, bus.err_o}, 0);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], "");

        // Reset asserted between clock edges in the middle of bit 0's low phase.
        bus.tx_nbits_i = 6'd8;
        bus.tx_data_i = 32'h80;
        bus.tx_stop_mode_i = 1'b0;
        bus.tx_start_i = 1'b1;
        @(negedge clk);
        bus.tx_start_i = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("midbit.oe_before_reset", oe, 1);
        #2 nrst = 1'b0;
        #1;
        check_eq("midbit.async_outputs", {oe, bus.busy_o, bus.done_o, bus.err_o}, 0);
        repeat (3) @(negedge clk);
        check_eq("midbit.held_outputs", {oe, bus.busy_o, bus.done_o, bus.err_o}, 0);
        nrst = 1'b1;
        repeat (4) @(negedge clk);
        run_vec(vecs[0], "after_reset.");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
